// File: rtl/ant_coord_feeder.sv
// ant_coord_feeder
// Front end of the sprite-rotation CORDIC. After a start it walks the ant sprite in
// raster order, one pixel per clock, and presents origin-centred fixed-point x/y plus
// the frame's rotation angle. A tag delay line as deep as the CORDIC latency carries
// {valid,col,row,last}, so the tags come out in step with the rotated results.
module ant_coord_feeder #(
   parameter int SPRITE_W   = 47,
   parameter int SPRITE_H   = 47,
   parameter int CORDIC_LAT = 19,
   parameter int X_SHIFT    = 4
) (
   input  logic        CLOCK_50,
   input  logic        resetn,
   input  logic        start,
   input  logic [12:0] angle_in,
   output logic        busy,
   output logic        done,
   output logic        in_valid,
   output logic [11:0] x_out,
   output logic [11:0] y_out,
   output logic [12:0] a_out,
   output logic        out_valid,
   output logic [5:0]  out_col,
   output logic [5:0]  out_row,
   output logic        out_last
);

   localparam int CX = (SPRITE_W - 1) / 2;
   localparam int CY = (SPRITE_H - 1) / 2;
   localparam int TAG_W = 14;
   localparam int CW = (CORDIC_LAT < 2) ? 1 : $clog2(CORDIC_LAT);
   localparam logic [5:0] LAST_COL = 6'(SPRITE_W - 1);
   localparam logic [5:0] LAST_ROW = 6'(SPRITE_H - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   state_t state_q, state_d;
   logic [5:0] col_q, col_d;
   logic [5:0] row_q, row_d;
   logic inValid_q, inValid_d;
   logic [11:0] xOut_q, xOut_d;
   logic [11:0] yOut_q, yOut_d;
   logic [12:0] angle_q, angle_d;
   logic [CW-1:0] drain_q, drain_d;

   logic present;
   logic pixelLast;
   logic signed [6:0] dx, dy;
   logic [11:0] dxExt, dyExt;
   logic [TAG_W-1:0] tagIn;
   logic [TAG_W-1:0] tagPipe_q [CORDIC_LAT];
   logic [TAG_W-1:0] tagOut;

   // The pixel currently on x_out/y_out is the final one of the frame
   assign pixelLast = (col_q == LAST_COL) && (row_q == LAST_ROW);

   // Frame state, pixel counters and the registered CORDIC input word
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         state_q   <= IDLE;
         col_q     <= '0;
         row_q     <= '0;
         inValid_q <= 1'b0;
         xOut_q    <= '0;
         yOut_q    <= '0;
         angle_q   <= '0;
         drain_q   <= '0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         row_q     <= row_d;
         inValid_q <= inValid_d;
         xOut_q    <= xOut_d;
         yOut_q    <= yOut_d;
         angle_q   <= angle_d;
         drain_q   <= drain_d;
      end
   end

   // Next state: pick the pixel to present next cycle, then centre and scale it
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      angle_d = angle_q;
      drain_d = drain_q;
      present = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               angle_d = angle_in;
               col_d   = '0;
               row_d   = '0;
               present = 1'b1;
            end
         end
         RUN: begin
            if (pixelLast) begin
               state_d = DRAIN;
               col_d   = '0;
               row_d   = '0;
               // One less than the latency so DONE lands right after out_last
               drain_d = CW'(CORDIC_LAT - 1);
            end else begin
               present = 1'b1;
               if (col_q == LAST_COL) begin
                  col_d = '0;
                  row_d = row_q + 6'd1;
               end else begin
                  col_d = col_q + 6'd1;
               end
            end
         end
         DRAIN: begin
            if (drain_q == '0) begin
               state_d = DONE;
            end else begin
               drain_d = drain_q - CW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      dx        = $signed({1'b0, col_d}) - 7'(CX);
      dy        = $signed({1'b0, row_d}) - 7'(CY);
      dxExt     = {{5{dx[6]}}, dx};
      dyExt     = {{5{dy[6]}}, dy};
      inValid_d = present;
      xOut_d    = present ? (dxExt << X_SHIFT) : 12'd0;
      yOut_d    = present ? (dyExt << X_SHIFT) : 12'd0;
   end

   // Tags only carry coordinates for real pixels so idle slots read as all zero
   assign tagIn = inValid_q ? {1'b1, col_q, row_q, pixelLast} : '0;

   // Tag delay line matched to the CORDIC latency, flushed by reset
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         for (int i = 0; i < CORDIC_LAT; i++) begin
            tagPipe_q[i] <= '0;
         end
      end else begin
         tagPipe_q[0] <= tagIn;
         for (int i = 1; i < CORDIC_LAT; i++) begin
            tagPipe_q[i] <= tagPipe_q[i-1];
         end
      end
   end

   assign tagOut    = tagPipe_q[CORDIC_LAT-1];
   assign out_valid = tagOut[13];
   assign out_col   = tagOut[12:7];
   assign out_row   = tagOut[6:1];
   assign out_last  = tagOut[0];

   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign in_valid = inValid_q;
   assign x_out    = xOut_q;
   assign y_out    = yOut_q;
   assign a_out    = angle_q;

endmodule

// File: tb/tb_ant_coord_feeder.sv
// Testbench for ant_coord_feeder: default-size instance checked every cycle against
// a frame-timeline model, plus a tiny 3x2 instance checked against literal tables.
module tb_ant_coord_feeder;

   localparam int W   = 47;
   localparam int H   = 47;
   localparam int LAT = 19;
   localparam int N   = W * H;
   localparam int CX  = (W - 1) / 2;
   localparam int CY  = (H - 1) / 2;

   logic CLOCK_50;
   logic resetn;
   logic start;
   logic [12:0] angle_in;
   logic busy, done, in_valid, out_valid, out_last;
   logic [11:0] x_out, y_out;
   logic [12:0] a_out;
   logic [5:0] out_col, out_row;

   logic startS;
   logic [12:0] angleS;
   logic busyS, doneS, ivS, ovS, lastS;
   logic [11:0] xS, yS;
   logic [12:0] aS;
   logic [5:0] colS, rowS;

   logic [53:0] dutVec;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit frameOn = 0;
   int sEdge = 0;
   logic [12:0] aExp = '0;
   int ivCount = 0;
   int ovCount = 0;
   bit checkEn = 0;

   logic [11:0] xTab [6] = '{12'hFF0, 12'h000, 12'h010, 12'hFF0, 12'h000, 12'h010};
   logic [11:0] yTab [6] = '{12'h000, 12'h000, 12'h000, 12'h010, 12'h010, 12'h010};
   logic [5:0] colTab [6] = '{6'd0, 6'd1, 6'd2, 6'd0, 6'd1, 6'd2};
   logic [5:0] rowTab [6] = '{6'd0, 6'd0, 6'd0, 6'd1, 6'd1, 6'd1};

   ant_coord_feeder dut (
      .CLOCK_50 (CLOCK_50),
      .resetn   (resetn),
      .start    (start),
      .angle_in (angle_in),
      .busy     (busy),
      .done     (done),
      .in_valid (in_valid),
      .x_out    (x_out),
      .y_out    (y_out),
      .a_out    (a_out),
      .out_valid(out_valid),
      .out_col  (out_col),
      .out_row  (out_row),
      .out_last (out_last)
   );

   ant_coord_feeder #(
      .SPRITE_W  (3),
      .SPRITE_H  (2),
      .CORDIC_LAT(4),
      .X_SHIFT   (4)
   ) dutSmall (
      .CLOCK_50 (CLOCK_50),
      .resetn   (resetn),
      .start    (startS),
      .angle_in (angleS),
      .busy     (busyS),
      .done     (doneS),
      .in_valid (ivS),
      .x_out    (xS),
      .y_out    (yS),
      .a_out    (aS),
      .out_valid(ovS),
      .out_col  (colS),
      .out_row  (rowS),
      .out_last (lastS)
   );

   assign dutVec = {busy, done, in_valid, x_out, y_out, a_out, out_valid, out_col, out_row, out_last};

   // 50 MHz clock
   initial begin
      CLOCK_50 = 1'b0;
      forever #10 CLOCK_50 = ~CLOCK_50;
   end

   // Single comparison with bookkeeping and a FAIL line on mismatch
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at edge %0d: actual=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   // Pulse start for one cycle; returns at the first cycle the frame is running
   task automatic applyStimulus(input logic [12:0] ang);
      start    = 1'b1;
      angle_in = ang;
      @(negedge CLOCK_50);
      start = 1'b0;
   endtask

   // Wait (bounded) for the final tag, then check completion handshake and counts
   task automatic waitForLast(input int limit);
      int n = 0;
      while (out_last !== 1'b1 && n < limit) begin
         @(negedge CLOCK_50);
         n++;
      end
      checkOutput("lastSeen", 64'(out_last), 64'(1));
      checkOutput("lastCol", 64'(out_col), 64'(46));
      checkOutput("lastRow", 64'(out_row), 64'(46));
      @(negedge CLOCK_50);
      checkOutput("doneAfterLast", 64'(done), 64'(1));
      @(negedge CLOCK_50);
      checkOutput("busyDropped", 64'(busy), 64'(0));
      checkOutput("inValidCount", 64'(ivCount), 64'(2209));
      checkOutput("outValidCount", 64'(ovCount), 64'(2209));
   endtask

   // Expected outputs from the frame timeline: k cycles after the accepting edge,
   // pixel k is on the input side and pixel k-LAT on the output side
   function automatic logic [53:0] modelVec();
      logic b, d, iv, ov, lst;
      logic [11:0] x, y;
      logic [5:0] c, r;
      int k, p;
      b = 0; d = 0; iv = 0; ov = 0; lst = 0;
      x = '0; y = '0; c = '0; r = '0;
      if (frameOn) begin
         k = cyc - sEdge;
         if (k < N) begin
            iv = 1'b1;
            x  = 12'(((k % W) - CX) * 16);
            y  = 12'(((k / W) - CY) * 16);
         end
         if (k >= LAT && k < LAT + N) begin
            p   = k - LAT;
            ov  = 1'b1;
            c   = 6'(p % W);
            r   = 6'(p / W);
            lst = (p == N - 1);
         end
         d = (k == LAT + N);
         b = (k <= LAT + N);
      end
      return {b, d, iv, x, y, aExp, ov, c, r, lst};
   endfunction

   // Model bookkeeping at each edge: reset, start acceptance only when idle
   always @(posedge CLOCK_50) begin
      cyc++;
      if (!resetn) begin
         frameOn = 0;
         aExp    = '0;
      end else if (start && !(frameOn && (cyc - 1 - sEdge) <= LAT + N)) begin
         frameOn = 1;
         sEdge   = cyc;
         aExp    = angle_in;
         ivCount = 0;
         ovCount = 0;
      end
   end

   // Every-cycle comparison of the default instance against the model
   always @(negedge CLOCK_50) begin
      if (checkEn) begin
         checkOutput("cycle", 64'(dutVec), 64'(modelVec()));
         if (in_valid) ivCount++;
         if (out_valid) ovCount++;
      end
   end

   // Directed scenario sequence
   initial begin
      logic sawOv;
      int smallOv;
      resetn   = 1'b0;
      start    = 1'b0;
      angle_in = '0;
      startS   = 1'b0;
      angleS   = '0;
      repeat (3) @(negedge CLOCK_50);
      checkEn = 1;
      checkOutput("resetState", 64'(dutVec), 64'(0));
      checkOutput("resetStateSmall",
                  64'({busyS, doneS, ivS, xS, yS, aS, ovS, colS, rowS, lastS}), 64'(0));
      resetn = 1'b1;
      @(negedge CLOCK_50);

      // Small sprite: raster order, offsets, tag latency and done timing
      startS = 1'b1;
      angleS = 13'h0111;
      @(negedge CLOCK_50);
      startS  = 1'b0;
      smallOv = 0;
      for (int k = 0; k < 12; k++) begin
         if (k < 6) begin
            checkOutput("smallIv", 64'(ivS), 64'(1));
            checkOutput("smallX", 64'(xS), 64'(xTab[k]));
            checkOutput("smallY", 64'(yS), 64'(yTab[k]));
         end else begin
            checkOutput("smallIvLow", 64'(ivS), 64'(0));
         end
         if (k >= 4 && k < 10) begin
            checkOutput("smallOv", 64'(ovS), 64'(1));
            checkOutput("smallCol", 64'(colS), 64'(colTab[k-4]));
            checkOutput("smallRow", 64'(rowS), 64'(rowTab[k-4]));
            checkOutput("smallLast", 64'(lastS), 64'(k == 9));
         end else begin
            checkOutput("smallOvLow", 64'(ovS), 64'(0));
         end
         checkOutput("smallDone", 64'(doneS), 64'(k == 10));
         if (ovS) smallOv++;
         @(negedge CLOCK_50);
      end
      checkOutput("smallOvCount", 64'(smallOv), 64'(6));
      checkOutput("smallAngle", 64'(aS), 64'(13'h0111));

      // Frame 1 with stray start pulses during RUN and DRAIN
      applyStimulus(13'h0324);
      checkOutput("firstX", 64'(x_out), 64'(12'hE90));
      checkOutput("firstY", 64'(y_out), 64'(12'hE90));
      repeat (18) @(negedge CLOCK_50);
      checkOutput("ovBeforeLat", 64'(out_valid), 64'(0));
      @(negedge CLOCK_50);
      checkOutput("ovAtLat", 64'(out_valid), 64'(1));
      checkOutput("firstOutCol", 64'(out_col), 64'(0));
      checkOutput("firstOutRow", 64'(out_row), 64'(0));
      repeat (27) @(negedge CLOCK_50);
      checkOutput("pix46X", 64'(x_out), 64'(12'h170));
      checkOutput("pix46Y", 64'(y_out), 64'(12'hE90));
      repeat (54) @(negedge CLOCK_50);
      start    = 1'b1;
      angle_in = 13'h1FFF;
      @(negedge CLOCK_50);
      start = 1'b0;
      repeat (1003) @(negedge CLOCK_50);
      checkOutput("centreX", 64'(x_out), 64'(0));
      checkOutput("centreY", 64'(y_out), 64'(0));
      repeat (1111) @(negedge CLOCK_50);
      start = 1'b1;
      @(negedge CLOCK_50);
      start = 1'b0;
      waitForLast(100);
      checkOutput("angleKept", 64'(a_out), 64'(13'h0324));

      // Frame 2 with a new angle
      repeat (2) @(negedge CLOCK_50);
      checkOutput("angleBeforeStart2", 64'(a_out), 64'(13'h0324));
      applyStimulus(13'h065A);
      checkOutput("angleFrame2", 64'(a_out), 64'(13'h065A));
      waitForLast(3000);

      // Frame 3 aborted by reset at pixel 500
      repeat (3) @(negedge CLOCK_50);
      applyStimulus(13'h0324);
      repeat (500) @(negedge CLOCK_50);
      resetn = 1'b0;
      @(negedge CLOCK_50);
      checkOutput("abortState", 64'(dutVec), 64'(0));
      resetn = 1'b1;
      sawOv  = 1'b0;
      repeat (25) begin
         @(negedge CLOCK_50);
         sawOv = sawOv | out_valid;
      end
      checkOutput("noStaleValid", 64'(sawOv), 64'(0));

      // Frame 4 after the abort starts cleanly from (0,0)
      applyStimulus(13'h0ABC);
      checkOutput("restartIv", 64'(in_valid), 64'(1));
      checkOutput("restartX", 64'(x_out), 64'(12'hE90));
      checkOutput("restartY", 64'(y_out), 64'(12'hE90));
      waitForLast(3000);
      checkOutput("angleFrame4", 64'(a_out), 64'(13'h0ABC));

      checkEn = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
